// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words ahead of the IF stage over a
// single-outstanding variable-latency bus; any PC discontinuity flushes and refetches.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  localparam int unsigned CW      = $clog2(DEPTH + 1),
  localparam int unsigned PW      = $clog2(DEPTH)
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [31:0]   iPC,
  input  logic          iAdvance,
  output logic [31:0]   oInstr,
  output logic          oStall,
  output logic [CW-1:0] oCount,
  output logic          oMemRead,
  output logic [31:0]   oMemAddress,
  input  logic          iMemReady,
  input  logic          iMemValid,
  input  logic [31:0]   iMemData
);

  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_head_addr, r_next_fetch;
  logic          r_pending, r_drop;

  logic [PW-1:0] w_rd_ptr_d, w_wr_ptr_d;
  logic [CW-1:0] w_count_d;
  logic [31:0]   w_head_addr_d, w_next_fetch_d;
  logic          w_pending_d, w_drop_d;

  logic          w_flush, w_hit, w_pop, w_resp, w_push, w_accept, w_room, w_mem_read;
  logic [CW:0]   w_inflight;

  assign w_flush    = (iPC != r_head_addr);
  assign w_hit      = !w_flush && (r_count != '0);
  assign w_pop      = w_hit && iAdvance;
  assign w_resp     = iMemValid && r_pending && !w_flush;
  assign w_push     = w_resp && !r_drop;
  // Queued entries plus the outstanding request each hold a slot, so a push never overflows.
  assign w_inflight = {1'b0, r_count} + {{CW{1'b0}}, r_pending};
  assign w_room     = (w_inflight < (CW + 1)'(DEPTH));
  assign w_mem_read = iRST && !w_flush && (!r_pending || iMemValid) && w_room;
  assign w_accept   = w_mem_read && iMemReady;

  assign oStall      = !w_hit;
  assign oInstr      = w_hit ? r_data[r_rd_ptr] : 32'h0;
  assign oCount      = r_count;
  assign oMemRead    = w_mem_read;
  assign oMemAddress = r_next_fetch;

  always_comb begin
    w_rd_ptr_d     = r_rd_ptr;
    w_wr_ptr_d     = r_wr_ptr;
    w_count_d      = r_count;
    w_head_addr_d  = r_head_addr;
    w_next_fetch_d = r_next_fetch;
    w_pending_d    = r_pending;
    w_drop_d       = r_drop;
    if (w_flush) begin
      w_rd_ptr_d     = '0;
      w_wr_ptr_d     = '0;
      w_count_d      = '0;
      w_head_addr_d  = iPC;
      w_next_fetch_d = iPC;
      // A response still in flight belongs to the old stream and must be swallowed.
      if (r_pending && iMemValid) begin
        w_pending_d = 1'b0;
        w_drop_d    = 1'b0;
      end else if (r_pending) begin
        w_drop_d = 1'b1;
      end
    end else begin
      if (w_pop) begin
        w_rd_ptr_d    = r_rd_ptr + 1'b1;
        w_head_addr_d = r_head_addr + 32'd4;
      end
      if (w_push) begin
        w_wr_ptr_d = r_wr_ptr + 1'b1;
      end
      if (w_resp && r_drop) begin
        w_drop_d = 1'b0;
      end
      if (w_accept) begin
        w_pending_d    = 1'b1;
        w_next_fetch_d = r_next_fetch + 32'd4;
      end else if (w_resp) begin
        w_pending_d = 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + 1'b1;
        2'b01:   w_count_d = r_count - 1'b1;
        default: w_count_d = r_count;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_head_addr  <= RESET_PC;
      r_next_fetch <= RESET_PC;
      r_pending    <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_rd_ptr     <= w_rd_ptr_d;
      r_wr_ptr     <= w_wr_ptr_d;
      r_count      <= w_count_d;
      r_head_addr  <= w_head_addr_d;
      r_next_fetch <= w_next_fetch_d;
      r_pending    <= w_pending_d;
      r_drop       <= w_drop_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= iMemData;
    end
  end

endmodule
